// File: rtl/prod_sched_pkg.sv
// Shared types and constants for the producer scheduler.
package prod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] MODE_FIB = 2'b00;
  localparam logic [1:0] MODE_TMR = 2'b01;
  localparam logic [1:0] MODE_RR  = 2'b10;

  localparam logic SRC_FIB = 1'b0;
  localparam logic SRC_TMR = 1'b1;

  // Source forced by a fixed mode; the unused encoding 11 behaves as Fibonacci-only.
  function automatic logic mode_src(input logic [1:0] mode);
    return (mode == MODE_TMR) ? SRC_TMR : SRC_FIB;
  endfunction

endpackage

// File: rtl/prod_sched_if.sv
// Producer handshakes and FIFO write port shared by the scheduler.
interface prod_sched_if #(
  parameter int DATA_W = 16
);
  logic              fib_valid;
  logic [DATA_W-1:0] fib_data;
  logic              fib_ack;
  logic              tmr_valid;
  logic [DATA_W-1:0] tmr_data;
  logic              tmr_ack;
  logic              buffer_full;
  logic              data_1_en;
  logic [DATA_W-1:0] data_1;

  modport master (
    input  fib_valid, fib_data, tmr_valid, tmr_data, buffer_full,
    output fib_ack, tmr_ack, data_1_en, data_1
  );

  modport slave (
    output fib_valid, fib_data, tmr_valid, tmr_data, buffer_full,
    input  fib_ack, tmr_ack, data_1_en, data_1
  );
endinterface

// File: rtl/prod_sched_rr_sel.sv
// Source grant register with burst counting and work-conserving handover.
module prod_rr_sel
  import prod_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       run,
  input  logic       accept,
  input  logic [1:0] mode,
  input  logic       fib_valid,
  input  logic       tmr_valid,
  output logic       src_sel
);

  localparam int BW = $clog2(BURST + 1);

  logic [BW-1:0] burst_cnt;
  logic          sel_valid;
  logic          other_valid;
  logic          burst_done;

  // Valid of the granted source versus the other, and end-of-burst detection.
  always_comb begin
    sel_valid   = src_sel ? tmr_valid : fib_valid;
    other_valid = src_sel ? fib_valid : tmr_valid;
    burst_done  = accept && (burst_cnt == BW'(BURST - 1));
  end

  // Grant register: fixed modes force the source, round-robin hands over per burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_sel   <= SRC_FIB;
      burst_cnt <= '0;
    end else if (go) begin
      src_sel   <= mode_src(mode);
      burst_cnt <= '0;
    end else if (mode != MODE_RR) begin
      src_sel   <= mode_src(mode);
      burst_cnt <= '0;
    end else if (run) begin
      if (burst_done) begin
        // A finished burst only hands over when the other source has work;
        // otherwise the current source starts a fresh burst without a gap.
        if (other_valid) src_sel <= ~src_sel;
        burst_cnt <= '0;
      end else if (!sel_valid && other_valid) begin
        src_sel   <= ~src_sel;
        burst_cnt <= '0;
      end else if (accept) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/prod_sched.sv
// Shares the FIFO write port between the Fibonacci and Timer producers.
module prod_sched
  import prod_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int BURST       = 4,
  parameter int STALL_LIMIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [1:0]   mode,
  prod_sched_if.master bus,
  output logic         src_sel,
  output logic         busy,
  output logic         stall_err,
  output logic [15:0]  word_cnt
);

  localparam int SW = $clog2(STALL_LIMIT + 1);

  state_t            state_q;
  state_t            state_d;
  logic              go;
  logic              run;
  logic              accept;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              data_1_en_q;
  logic [DATA_W-1:0] data_1_q;
  logic              busy_q;
  logic              stall_err_q;
  logic [15:0]       word_cnt_q;
  logic [SW-1:0]     stall_cnt_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state; stop outranks start and backpressure.
  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          go      = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop)                 state_d = ST_IDLE;
        else if (bus.buffer_full) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (stop)                  state_d = ST_IDLE;
        else if (!bus.buffer_full) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Accept and acks; the write-strobe term spaces words two cycles apart.
  always_comb begin
    run         = (state_q == ST_RUN);
    sel_valid   = src_sel ? bus.tmr_valid : bus.fib_valid;
    sel_data    = src_sel ? bus.tmr_data  : bus.fib_data;
    accept      = run && !stop && !bus.buffer_full && !data_1_en_q && sel_valid;
    bus.fib_ack = accept && (src_sel == SRC_FIB);
    bus.tmr_ack = accept && (src_sel == SRC_TMR);
  end

  // Registered FIFO write port and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_1_en_q <= 1'b0;
      data_1_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      data_1_en_q <= accept;
      if (accept) data_1_q <= sel_data;
      busy_q <= (state_d != ST_IDLE);
    end
  end

  // Accepted-word counter, cleared on start and wrapping at the top.
  always_ff @(posedge clk) begin
    if (rst)         word_cnt_q <= '0;
    else if (go)     word_cnt_q <= '0;
    else if (accept) word_cnt_q <= word_cnt_q + 16'd1;
  end

  // Stall detection: counts full cycles in HOLD, flag is sticky until start.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else if (go) begin
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else if (run && bus.buffer_full) begin
      stall_cnt_q <= '0;
    end else if ((state_q == ST_HOLD) && bus.buffer_full &&
                 (stall_cnt_q != SW'(STALL_LIMIT))) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
      if (stall_cnt_q == SW'(STALL_LIMIT - 1)) stall_err_q <= 1'b1;
    end
  end

  prod_rr_sel #(
    .BURST(BURST)
  ) u_rr_sel (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .run      (run),
    .accept   (accept),
    .mode     (mode),
    .fib_valid(bus.fib_valid),
    .tmr_valid(bus.tmr_valid),
    .src_sel  (src_sel)
  );

  assign bus.data_1_en = data_1_en_q;
  assign bus.data_1    = data_1_q;
  assign busy          = busy_q;
  assign stall_err     = stall_err_q;
  assign word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_prod_sched.sv
// Bench for prod_sched: cycle model compare plus directed scenarios.
module tb_prod_sched;

  localparam int DATA_W      = 16;
  localparam int BURST       = 4;
  localparam int STALL_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [1:0]  mode;
  logic        src_sel, busy, stall_err;
  logic [15:0] word_cnt;

  prod_sched_if #(.DATA_W(DATA_W)) bus ();

  prod_sched #(
    .DATA_W(DATA_W), .BURST(BURST), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .bus(bus),
    .src_sel(src_sel), .busy(busy), .stall_err(stall_err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Producers and logs
  bit          fib_on, tmr_on, fib_took, tmr_took;
  int          fib_a, fib_b, tmr_k;
  int          fib_acks, tmr_acks;
  logic [15:0] wr_q[$];
  int          wr_cyc[$];

  // Model: states 0 idle, 1 run, 2 hold
  int          m_state = 0;
  bit          m_src = 0, m_en = 0, m_err = 0, m_busy = 0;
  int          m_burst = 0, m_stall = 0;
  logic [15:0] m_data = '0, m_word = '0;
  bit          s_v, o_v, m_acc, m_go;
  int          n_state;
  logic [15:0] s_d;

  always @(negedge clk) begin
    cyc++;
    s_v   = m_src ? bus.tmr_valid : bus.fib_valid;
    o_v   = m_src ? bus.fib_valid : bus.tmr_valid;
    s_d   = m_src ? bus.tmr_data  : bus.fib_data;
    m_acc = (m_state == 1) && !stop && !bus.buffer_full && !m_en && s_v;
    if (chk_en) begin
      chk("fib_ack",   32'(bus.fib_ack),   32'(m_acc && !m_src));
      chk("tmr_ack",   32'(bus.tmr_ack),   32'(m_acc && m_src));
      chk("data_1_en", 32'(bus.data_1_en), 32'(m_en));
      chk("data_1",    32'(bus.data_1),    32'(m_data));
      chk("src_sel",   32'(src_sel),       32'(m_src));
      chk("busy",      32'(busy),          32'(m_busy));
      chk("stall_err", 32'(stall_err),     32'(m_err));
      chk("word_cnt",  32'(word_cnt),      32'(m_word));
    end
    fib_took = bus.fib_ack;
    tmr_took = bus.tmr_ack;
    if (bus.fib_ack) fib_acks++;
    if (bus.tmr_ack) tmr_acks++;
    if (bus.data_1_en) begin
      wr_q.push_back(bus.data_1);
      wr_cyc.push_back(cyc);
    end
    if (rst) begin
      m_state = 0; m_src = 0; m_en = 0; m_err = 0; m_busy = 0;
      m_burst = 0; m_stall = 0; m_data = '0; m_word = '0;
    end else begin
      m_go = (m_state == 0) && start && !stop;
      if (m_go) m_err = 0;
      else if (m_state == 1 && bus.buffer_full) m_stall = 0;
      else if (m_state == 2 && bus.buffer_full) begin
        if (m_stall < STALL_LIMIT) m_stall++;
        if (m_stall == STALL_LIMIT) m_err = 1;
      end
      if (m_go || mode != 2'b10) begin
        m_src = (mode == 2'b01); m_burst = 0;
      end else if (m_state == 1) begin
        if (m_acc && m_burst + 1 == BURST) begin
          if (o_v) m_src = !m_src;
          m_burst = 0;
        end else if (!s_v && o_v) begin
          m_src = !m_src; m_burst = 0;
        end else if (m_acc) m_burst++;
      end
      m_en = m_acc;
      if (m_acc) m_data = s_d;
      if (m_go) m_word = '0;
      else if (m_acc) m_word = m_word + 16'd1;
      if (m_state == 0)      n_state = m_go ? 1 : 0;
      else if (stop)         n_state = 0;
      else                   n_state = bus.buffer_full ? 2 : 1;
      m_state = n_state;
      m_busy  = (n_state != 0);
    end
  end

  task automatic drive();
    bus.fib_valid = fib_on;
    bus.fib_data  = fib_a[15:0];
    bus.tmr_valid = tmr_on;
    bus.tmr_data  = 16'h8000 | tmr_k[15:0];
  endtask

  task automatic reset_prod();
    fib_a = 1; fib_b = 1; tmr_k = 0;
    drive();
  endtask

  task automatic clear_logs();
    wr_q.delete(); wr_cyc.delete();
    fib_acks = 0; tmr_acks = 0;
  endtask

  task automatic step();
    int t;
    @(posedge clk);
    #1;
    if (fib_took) begin
      t = fib_a + fib_b; fib_a = fib_b; fib_b = t;
    end
    if (tmr_took) tmr_k++;
    drive();
  endtask

  function automatic logic [15:0] getw(input int i);
    if (i < wr_q.size()) return wr_q[i];
    return 16'hDEAD;
  endfunction

  task automatic wait_writes(input int n, input int budget, input string name);
    for (int i = 0; i < budget && wr_q.size() < n; i++) step();
    chk(name, 32'(wr_q.size() >= n), 32'd1);
  endtask

  task automatic wait_fib_ack(input int budget, input string name);
    for (int i = 0; i < budget && fib_acks < 1; i++) step();
    chk(name, 32'(fib_acks >= 1), 32'd1);
  endtask

  task automatic do_stop();
    stop = 1'b1; step(); stop = 1'b0; step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int fa, fb, ft, tk;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
    bus.buffer_full = 1'b0;
    fib_on = 0; tmr_on = 0; fib_took = 0; tmr_took = 0;
    reset_prod(); clear_logs();
    step(); chk_en = 1'b1; step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en",   32'(bus.data_1_en), 32'd0);
    chk("rst_data", 32'(bus.data_1), 32'd0);
    chk("rst_cnt",  32'(word_cnt), 32'd0);
    chk("rst_err",  32'(stall_err), 32'd0);
    chk("rst_sel",  32'(src_sel), 32'd0);
    rst = 1'b0;

    // Fibonacci-only: three words 1,1,2
    mode = 2'b00; fib_on = 1; drive(); clear_logs();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 20 && fib_acks < 3; i++) step();
    fib_on = 0; drive();
    step(); step(); step();
    chk("t1_nwr", 32'(wr_q.size()), 32'd3);
    chk("t1_w0", 32'(getw(0)), 32'h0001);
    chk("t1_w1", 32'(getw(1)), 32'h0001);
    chk("t1_w2", 32'(getw(2)), 32'h0002);
    chk("t1_cnt", 32'(word_cnt), 32'd3);
    chk("t1_tmr", 32'(tmr_acks), 32'd0);
    if (wr_cyc.size() >= 2) chk("t1_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd2);
    do_stop();

    // Round-robin, both sources always valid
    reset_prod(); clear_logs();
    mode = 2'b10; fib_on = 1; tmr_on = 1; drive();
    start = 1'b1; step(); start = 1'b0;
    wait_writes(16, 60, "t2_timeout");
    fib_on = 0; tmr_on = 0; drive();
    fa = 1; fb = 1; tk = 0;
    for (int i = 0; i < 16; i++) begin
      w = getw(i);
      if (((i / 4) % 2) == 0) begin
        chk("t2_fib", 32'(w), 32'(fa));
        ft = fa + fb; fa = fb; fb = ft;
      end else begin
        chk("t2_tmr", 32'(w), 32'(16'h8000 | tk[15:0]));
        tk++;
      end
    end
    do_stop();

    // Round-robin with Timer idle: no handover, no gaps
    reset_prod(); clear_logs();
    mode = 2'b10; fib_on = 1; tmr_on = 0; drive();
    start = 1'b1; step(); start = 1'b0;
    wait_writes(12, 40, "t3_timeout");
    for (int i = 1; i < 12 && i < wr_cyc.size(); i++)
      chk("t3_gap", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd2);
    chk("t3_sel", 32'(src_sel), 32'd0);
    chk("t3_tmr", 32'(tmr_acks), 32'd0);

    // Backpressure for 10 cycles
    clear_logs(); bus.buffer_full = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 8) chk("t4_err_early", 32'(stall_err), 32'd0);
      if (k == 9) chk("t4_err_set", 32'(stall_err), 32'd1);
    end
    chk("t4_noack", 32'(fib_acks), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    bus.buffer_full = 1'b0;
    wait_fib_ack(10, "t4_resume");
    chk("t4_sticky", 32'(stall_err), 32'd1);

    // Stop in the cycle right after an accept
    clear_logs();
    stop = 1'b1; step(); stop = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_wr", 32'(wr_q.size()), 32'd1);
    step(); step(); step(); step();
    chk("t5_noack", 32'(fib_acks), 32'd0);

    // Start and stop together from IDLE
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0; step();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_err", 32'(stall_err), 32'd1);
    chk("t6_noack", 32'(fib_acks), 32'd0);

    // Counter wrap
    fib_on = 0; drive(); mode = 2'b00;
    start = 1'b1; step(); start = 1'b0;
    chk("t7_errclr", 32'(stall_err), 32'd0);
    chk("t7_busy", 32'(busy), 32'd1);
    force dut.word_cnt_q = 16'hFFFF;
    m_word = 16'hFFFF;
    #1 release dut.word_cnt_q;
    clear_logs(); fib_on = 1; drive();
    wait_fib_ack(6, "t7_timeout");
    fib_on = 0; drive();
    chk("t7_wrap", 32'(word_cnt), 32'h0000);
    step();
    chk("t7_wr", 32'(wr_q.size()), 32'd1);
    do_stop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
